mem32_access_initiator: RTL and testbench

//  Core-side initiator for the 32-bit data memory port: accepts byte/half/word load and store requests

---
 rtl/mem32_pkg.sv | 43 ++++
 rtl/mem32_lane_align.sv | 58 +++++
 rtl/mem32_access_initiator.sv | 187 ++++++++++++++++++
 tb/tb_mem32_access_initiator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem32_pkg.sv
// mem32_pkg: shared types and constants for the 32-bit data memory initiator.
//   Contents: op/size enums, the registered request struct, FSM state encodings,
//   response cause codes and WORD_BYTES.
package mem32_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_LR    = 2'd2,
        OP_SC    = 2'd3
    } mem32_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } mem32_size_e;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // rsp_cause codes
    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0] CAUSE_ACCESS     = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd3;

    // Request fields held for the life of one transaction (address kept separately,
    // its width is a module parameter).
    typedef struct packed {
        mem32_op_e   op;
        mem32_size_e size;
        logic        sext;
        logic [31:0] wdata;
    } mem32_req_t;

endpackage

// File: rtl/mem32_lane_align.sv
// mem32_lane_align: combinational byte-lane handling for one 32-bit word.
//   word      in  32  word read from memory
//   lane      in  2   byte offset within the word (addr[1:0])
//   size      in  2   access size
//   sext      in  1   sign-extend sub-word loads
//   wdata     in  32  right-justified store data
//   load_data out 32  selected lane, zero/sign extended
//   merged    out 32  word with the addressed lane(s) replaced by wdata
module mem32_lane_align
    import mem32_pkg::*;
(
    input  logic [31:0]  word,
    input  logic [1:0]   lane,
    input  mem32_size_e  size,
    input  logic         sext,
    input  logic [31:0]  wdata,
    output logic [31:0]  load_data,
    output logic [31:0]  merged
);

    logic [31:0]           shifted;
    logic [31:0]           wrep;
    logic [WORD_BYTES-1:0] byte_en;

    // Aligned accesses only reach here, so a plain right shift by the byte offset
    // puts the addressed lane at bit 0.
    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        load_data = shifted;
        wrep      = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
                wrep      = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
                wrep      = {2{wdata[15:0]}};
            end
            default: begin
                load_data = shifted;
                wrep      = wdata;
            end
        endcase
    end

    // Store data is replicated across lanes; the per-lane enable picks which lanes
    // take the new value and which keep the read word.
    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
        localparam logic [1:0] L = 2'(i);
        assign byte_en[i] = (size == SZ_WORD)
                          | ((size == SZ_HALF) & (lane[1] == L[1]))
                          | ((size == SZ_BYTE) & (lane == L));
        assign merged[8*i +: 8] = byte_en[i] ? wrep[8*i +: 8] : word[8*i +: 8];
    end

endmodule

// File: rtl/mem32_access_initiator.sv
// mem32_access_initiator: core-side initiator for the 32-bit data memory port.
//   Accepts byte/half/word LOAD/STORE/LR/SC, one at a time; sub-word stores are
//   done as read-modify-write because the memory only handles whole words.
//   Optional feature macro: MEM32_LR_SC_EN (LR/SC reservation tracking).
// Ports:
//   CLK, RESET_N (async, active low)
//   req_*   request handshake (req_ready high only in IDLE)
//   rsp_*   response handshake, held stable until rsp_ready
//   mem_*   word-aligned read/write ports, one-cycle write strobe,
//           read/write fault inputs and reservation-success flag
module mem32_access_initiator
    import mem32_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_exception,
    output logic [1:0]        rsp_cause,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_read_exception,
    input  logic              mem_write_exception,
    input  logic              mem_reservation
);

    logic [1:0]        state;
    mem32_req_t        req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        acc_cause;
    logic              acc_read_first;
    logic              sc_ok;
    logic [ADDR_W-1:0] req_word_addr;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign req_ready        = (state == ST_IDLE);
    assign rsp_valid        = (state == ST_RESP);
    // Decoded from state so an asynchronous reset drops the strobe immediately.
    assign mem_write_enable = (state == ST_WRITE);
    assign req_word_addr    = {req_addr[ADDR_W-1:2], 2'b00};

    // Loads and sub-word stores need the current word first; word stores and SC go
    // straight to WRITE.
    assign acc_read_first = (req_op == OP_LOAD) || (req_op == OP_LR) ||
                            ((req_op == OP_STORE) && (req_size != SZ_WORD));

    // Fault decode at accept; illegal size wins over misalignment.
    always_comb begin
        acc_cause = CAUSE_NONE;
        if (req_size == SZ_ILLEGAL)
            acc_cause = CAUSE_ILLEGAL;
`ifdef MEM32_LR_SC_EN
        else if (((req_op == OP_LR) || (req_op == OP_SC)) && (req_size != SZ_WORD))
            acc_cause = CAUSE_MISALIGNED;
`else
        else if (req_op == OP_SC)
            acc_cause = CAUSE_ILLEGAL;
`endif
        else if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
            acc_cause = CAUSE_MISALIGNED;
        else if ((req_size == SZ_HALF) && req_addr[0])
            acc_cause = CAUSE_MISALIGNED;
    end

`ifdef MEM32_LR_SC_EN
    logic              resv_valid;
    logic [ADDR_W-3:0] resv_addr;

    assign sc_ok = resv_valid && (resv_addr == req_addr[ADDR_W-1:2]) && mem_reservation;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else begin
            if ((state == ST_READ) && (req_q.op == OP_LR) && !mem_read_exception) begin
                resv_valid <= 1'b1;
                resv_addr  <= addr_q[ADDR_W-1:2];
            end
            // Any SC consumes the reservation; a plain store to the reserved word kills it.
            if (req_valid && req_ready &&
                ((req_op == OP_SC) ||
                 ((req_op == OP_STORE) && (req_addr[ADDR_W-1:2] == resv_addr))))
                resv_valid <= 1'b0;
        end
    end
`else
    logic unused_resv;
    assign unused_resv = mem_reservation;
    assign sc_ok       = 1'b0;
`endif

    mem32_lane_align u_align (
        .word      (mem_read_data[31:0]),
        .lane      (addr_q[1:0]),
        .size      (req_q.size),
        .sext      (req_q.sext),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state             <= ST_IDLE;
            req_q             <= '0;
            addr_q            <= '0;
            rsp_data          <= '0;
            rsp_exception     <= 1'b0;
            rsp_cause         <= CAUSE_NONE;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q         <= '{op:    mem32_op_e'(req_op),
                                           size:  mem32_size_e'(req_size),
                                           sext:  req_signed,
                                           wdata: req_wdata[31:0]};
                        addr_q        <= req_addr;
                        rsp_data      <= '0;
                        rsp_exception <= 1'b0;
                        rsp_cause     <= CAUSE_NONE;
                        if (acc_cause != CAUSE_NONE) begin
                            rsp_exception <= 1'b1;
                            rsp_cause     <= acc_cause;
                            state         <= ST_RESP;
                        end else if (acc_read_first) begin
                            mem_read_address  <= req_word_addr;
                            mem_write_address <= req_word_addr;
                            state             <= ST_READ;
                        end else if ((req_op == OP_SC) && !sc_ok) begin
                            rsp_data <= DATA_W'(1);
                            state    <= ST_RESP;
                        end else begin
                            mem_write_address <= req_word_addr;
                            mem_write_data    <= req_wdata;
                            state             <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_read_exception) begin
                        rsp_exception <= 1'b1;
                        rsp_cause     <= CAUSE_ACCESS;
                        state         <= ST_RESP;
                    end else if (req_q.op == OP_STORE) begin
                        mem_write_data <= DATA_W'(merged);
                        state          <= ST_WRITE;
                    end else begin
                        rsp_data <= DATA_W'(load_data);
                        state    <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    if (mem_write_exception) begin
                        rsp_exception <= 1'b1;
                        rsp_cause     <= CAUSE_ACCESS;
                    end
                    state <= ST_RESP;
                end
                default: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem32_access_initiator.sv
module tb_mem32_access_initiator;
    import mem32_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_exception;
    logic [1:0]  rsp_cause;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic        mem_write_enable;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_read_exception;
    logic        mem_write_exception;
    logic        mem_reservation = 1'b1;

    always #5 CLK = ~CLK;

    mem32_access_initiator dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_exception(rsp_exception), .rsp_cause(rsp_cause),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_read_exception(mem_read_exception),
        .mem_write_exception(mem_write_exception), .mem_reservation(mem_reservation)
    );

    // Memory model: 256 words, faults in the 0xExxx (read) and 0xDxxx (write) regions.
    logic [31:0] mem [0:255];
    logic        mem_init = 1'b0;
    int          wr_count;
    logic [31:0] last_waddr, last_wdata;

    assign mem_read_data       = mem[mem_read_address[9:2]];
    assign mem_read_exception  = (mem_read_address[15:12] == 4'hE);
    assign mem_write_exception = (mem_write_address[15:12] == 4'hD);

    always @(posedge CLK) begin
        if (mem_init) begin
            mem[8'h40] <= 32'h8899AABB;   // 0x100
            mem[8'h41] <= 32'h7F0080FF;   // 0x104
            mem[8'h42] <= 32'h01020304;   // 0x108
            mem[8'h80] <= 32'h0BADBEEF;   // 0x200
            mem[8'h00] <= 32'h0;
            wr_count   <= 0;
            last_waddr <= '0;
            last_wdata <= '0;
        end else if (mem_write_enable) begin
            wr_count   <= wr_count + 1;
            last_waddr <= mem_write_address;
            last_wdata <= mem_write_data;
            if (!mem_write_exception)
                mem[mem_write_address[9:2]] <= mem_write_data;
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_exc;
        logic [1:0]  exp_cause;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        exc;
        logic [1:0]  cause;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] d, input logic e, input logic [1:0] c,
                                input int lat, input int wr, input logic [31:0] wa,
                                input logic [31:0] wd);
        vec_t v;
        v.op = op; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_data = d; v.exp_exc = e; v.exp_cause = c; v.exp_lat = lat;
        v.exp_wr = wr; v.exp_waddr = wa; v.exp_wdata = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one request, score the response against the queued expectation, then
    // optionally hold rsp_ready low for 'hold' cycles checking stability.
    task automatic run_req(input int idx, input vec_t v, input int hold);
        exp_t e;
        int   lat;
        int   w0;
        @(negedge CLK);
        rsp_ready  = (hold == 0);
        req_valid  = 1'b1;
        req_op     = v.op;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        sb.push_back('{v.exp_data, v.exp_exc, v.exp_cause});
        w0 = wr_count;
        chk($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 16) begin
            @(negedge CLK);
            lat++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            chk($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
        end else begin
            chk($sformatf("v%0d rsp_data", idx), rsp_data, e.data);
            chk($sformatf("v%0d rsp_exception", idx), {31'b0, rsp_exception}, {31'b0, e.exc});
            chk($sformatf("v%0d rsp_cause", idx), {30'b0, rsp_cause}, {30'b0, e.cause});
            chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
            for (int h = 0; h < hold; h++) begin
                @(negedge CLK);
                chk($sformatf("v%0d hold rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
                chk($sformatf("v%0d hold rsp_data", idx), rsp_data, e.data);
                chk($sformatf("v%0d hold req_ready", idx), {31'b0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        chk($sformatf("v%0d writes", idx), wr_count - w0, v.exp_wr);
        if (v.exp_wr > 0) begin
            chk($sformatf("v%0d waddr", idx), last_waddr, v.exp_waddr);
            chk($sformatf("v%0d wdata", idx), last_wdata, v.exp_wdata);
        end
    endtask

    initial begin
        int w0;
        vec_t v;

        // Reset and memory preload
        mem_init = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        mem_init = 1'b0;
        chk("rst req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst mem_we", {31'b0, mem_write_enable}, 32'd0);
        chk("rst mem_raddr", mem_read_address, 32'd0);
        chk("rst mem_wdata", mem_write_data, 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        RESET_N = 1'b1;

        // op, size, sgn, addr, wdata, exp data, exc, cause, lat, writes, waddr, wdata
        vt.push_back(mk(0, 0, 1, 32'h102, 0, 32'hFFFFFF99, 0, 0, 2, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 32'h102, 0, 32'h00000099, 0, 0, 2, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 32'h100, 0, 32'hFFFFAABB, 0, 0, 2, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 32'h102, 0, 32'h00008899, 0, 0, 2, 0, 0, 0));
        vt.push_back(mk(0, 2, 0, 32'h100, 0, 32'h8899AABB, 0, 0, 2, 0, 0, 0));
        vt.push_back(mk(0, 2, 0, 32'h101, 0, 32'h0, 1, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 32'h103, 0, 32'h0, 1, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 3, 0, 32'h100, 0, 32'h0, 1, 3, 1, 0, 0, 0));
`ifdef MEM32_LR_SC_EN
        vt.push_back(mk(3, 2, 0, 32'h100, 32'h77, 32'h1, 0, 0, 1, 0, 0, 0));
`else
        vt.push_back(mk(3, 2, 0, 32'h100, 32'h77, 32'h0, 1, 3, 1, 0, 0, 0));
`endif
        vt.push_back(mk(1, 1, 0, 32'h102, 32'h1234, 32'h0, 0, 0, 3, 1, 32'h100, 32'h1234AABB));
        vt.push_back(mk(0, 2, 0, 32'h100, 0, 32'h1234AABB, 0, 0, 2, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 32'h101, 32'hFFFFFF5A, 32'h0, 0, 0, 3, 1, 32'h100, 32'h12345ABB));
        vt.push_back(mk(1, 2, 0, 32'h104, 32'hCAFEF00D, 32'h0, 0, 0, 2, 1, 32'h104, 32'hCAFEF00D));
        vt.push_back(mk(0, 0, 1, 32'h107, 0, 32'hFFFFFFCA, 0, 0, 2, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 32'h101, 32'h5555, 32'h0, 1, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 2, 0, 32'hE000, 0, 32'h0, 1, 2, 2, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 32'hE001, 32'h11, 32'h0, 1, 2, 2, 0, 0, 0));
        vt.push_back(mk(1, 2, 0, 32'hD000, 32'h600D, 32'h0, 1, 2, 2, 1, 32'hD000, 32'h600D));
        vt.push_back(mk(2, 2, 0, 32'h104, 0, 32'hCAFEF00D, 0, 0, 2, 0, 0, 0));

        foreach (vt[i]) run_req(i, vt[i], 0);

        // Response held off by rsp_ready for 5 cycles
        run_req(100, mk(0, 2, 0, 32'h100, 0, 32'h12345ABB, 0, 0, 2, 0, 0, 0), 5);

        // Reset asserted while the write strobe is up
        @(negedge CLK);
        req_valid = 1'b1; req_op = 2'd1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h108; req_wdata = 32'hDEADBEEF;
        w0 = wr_count;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("rstmid we_in_write", {31'b0, mem_write_enable}, 32'd1);
        #1 RESET_N = 1'b0;
        #1;
        chk("rstmid we_dropped", {31'b0, mem_write_enable}, 32'd0);
        chk("rstmid rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstmid mem_wdata", mem_write_data, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rstmid req_ready", {31'b0, req_ready}, 32'd1);
        chk("rstmid writes", wr_count - w0, 32'd0);
        run_req(200, mk(0, 2, 0, 32'h108, 0, 32'h01020304, 0, 0, 2, 0, 0, 0), 0);

`ifdef MEM32_LR_SC_EN
        run_req(300, mk(2, 2, 0, 32'h200, 0, 32'h0BADBEEF, 0, 0, 2, 0, 0, 0), 0);
        run_req(301, mk(3, 2, 0, 32'h200, 32'h55, 32'h0, 0, 0, 2, 1, 32'h200, 32'h55), 0);
        run_req(302, mk(3, 2, 0, 32'h200, 32'h66, 32'h1, 0, 0, 1, 0, 0, 0), 0);
        run_req(303, mk(2, 2, 0, 32'h200, 0, 32'h55, 0, 0, 2, 0, 0, 0), 0);
        run_req(304, mk(1, 2, 0, 32'h200, 32'h99, 32'h0, 0, 0, 2, 1, 32'h200, 32'h99), 0);
        run_req(305, mk(3, 2, 0, 32'h200, 32'hAA, 32'h1, 0, 0, 1, 0, 0, 0), 0);
        run_req(306, mk(2, 0, 0, 32'h200, 0, 32'h0, 1, 1, 1, 0, 0, 0), 0);
`endif

        chk("scoreboard empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
